// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with 2-of-3 majority-vote bit
// sampling, per-frame error tagging and a show-ahead RX FIFO.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   baud_div        clocks per bit (values below 4 behave as 4)
//   parity_mode     0 none, 1 even, 2 odd, 3 none (latched at start edge)
//   stop_bits       0 one stop bit, 1 two stop bits (latched at start edge)
//   uart_rxd        asynchronous serial input, idle high
//   rx_data         FIFO head data (0 when empty)
//   rx_parity_err   FIFO head parity error flag (0 when empty)
//   rx_frame_err    FIFO head stop-bit error flag (0 when empty)
//   rx_valid        FIFO non-empty
//   rx_ready        consumer pops the head when rx_valid && rx_ready
//   rx_level        number of entries held
//   rx_overrun      sticky: a frame was dropped because the FIFO was full
//   overrun_clr     clears rx_overrun (a coincident set wins)
//   rx_break        one-cycle break indication
//
// Build option
//   UART_RX_BREAK_DETECT_EN: an all-zero frame (data, parity, stop bits) is
//   not stored and pulses rx_break instead. Without it rx_break is tied 0
//   and such a frame is stored as data 0 with a frame error.

module uart_rx_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [15:0]                      baud_div,
  input  logic [1:0]                       parity_mode,
  input  logic                             stop_bits,
  input  logic                             uart_rxd,
  output logic [DATA_W-1:0]                rx_data,
  output logic                             rx_parity_err,
  output logic                             rx_frame_err,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_level,
  output logic                             rx_overrun,
  input  logic                             overrun_clr,
  output logic                             rx_break
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  typedef struct packed {
    logic              perr;
    logic              ferr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser and start-edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxd_prev;
  logic                   w_rxd;
  logic                   w_start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], uart_rxd};
      r_rxd_prev <= w_rxd;
    end
  end

  assign w_rxd        = r_sync[SYNC_STAGES-1];
  // Only a 1->0 transition starts a frame, so a line held low never re-triggers
  assign w_start_edge = r_rxd_prev & ~w_rxd;

  // ---------------------------------------------------------------------
  // Bit timer decode
  // ---------------------------------------------------------------------
  logic [15:0] r_cnt;
  logic [15:0] w_b;
  logic [15:0] w_h;
  logic        w_smp0;
  logic        w_smp1;
  logic        w_decide;
  logic        w_bnd;

  assign w_b      = (baud_div < 16'd4) ? 16'd4 : baud_div;
  assign w_h      = {1'b0, w_b[15:1]};
  assign w_smp0   = (r_cnt == (w_h - 16'd1));
  assign w_smp1   = (r_cnt == w_h);
  assign w_decide = (r_cnt == (w_h + 16'd1));
  assign w_bnd    = (r_cnt == (w_b - 16'd1));

  // ---------------------------------------------------------------------
  // Receive FSM state
  // ---------------------------------------------------------------------
  state_t            r_state;
  logic              r_s0;
  logic              r_s1;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_perr;
  logic              r_ferr;
  logic              r_par_en;
  logic              r_odd;
  logic              r_two_stop;
  logic              w_vote;
  logic              w_final;
  logic              w_is_break;
  logic              w_push;
  entry_t            w_new;

  // Majority of the samples at h-1, h and the live sample at h+1
  assign w_vote  = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);

  // Decision point of the last stop bit of the frame
  assign w_final = w_decide &&
                   (((r_state == S_STOP1) && !r_two_stop) || (r_state == S_STOP2));

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_allzero;
  logic r_brk;
  assign w_is_break = w_final && r_allzero && !w_vote;
  assign rx_break   = r_brk;
`else
  assign w_is_break = 1'b0;
  assign rx_break   = 1'b0;
`endif

  assign w_push     = w_final && !w_is_break;
  assign w_new.perr = r_perr;
  assign w_new.ferr = r_ferr | ~w_vote;
  assign w_new.data = r_shift;

  // Frame sequencer: timer, sampling, shifting and error accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_par_en   <= 1'b0;
      r_odd      <= 1'b0;
      r_two_stop <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      r_allzero  <= 1'b0;
      r_brk      <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_BREAK_DETECT_EN
      r_brk <= w_is_break;
      if (w_decide && w_vote && (r_state != S_START)) r_allzero <= 1'b0;
`endif
      if (r_state != S_IDLE) begin
        r_cnt <= w_bnd ? 16'd0 : (r_cnt + 16'd1);
        if (w_smp0) r_s0 <= w_rxd;
        if (w_smp1) r_s1 <= w_rxd;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start_edge) begin
            r_state    <= S_START;
            r_par_en   <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
            r_odd      <= (parity_mode == 2'd2);
            r_two_stop <= stop_bits;
            r_par      <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_bit_cnt  <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_allzero  <= 1'b1;
`endif
          end
        end

        S_START: begin
          if (w_decide && w_vote) begin
            r_state <= S_IDLE;
          end else if (w_bnd) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end

        S_DATA: begin
          if (w_decide) begin
            r_shift <= {w_vote, r_shift[DATA_W-1:1]};
            r_par   <= r_par ^ w_vote;
          end
          if (w_bnd) begin
            if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
              r_state <= r_par_en ? S_PARITY : S_STOP1;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (w_decide) r_perr <= r_odd ? ~(r_par ^ w_vote) : (r_par ^ w_vote);
          if (w_bnd) r_state <= S_STOP1;
        end

        S_STOP1: begin
          if (w_decide && !w_vote) r_ferr <= 1'b1;
          if (w_final) begin
            r_state <= S_IDLE;
          end else if (w_bnd) begin
            r_state <= S_STOP2;
          end
        end

        S_STOP2: begin
          if (w_decide && !w_vote) r_ferr <= 1'b1;
          if (w_final) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO with registered show-ahead head
  // ---------------------------------------------------------------------
  entry_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_valid;
  logic             r_overrun;
  entry_t           r_head;

  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic [PTR_W-1:0] w_rd_ptr_n;
  logic [LVL_W-1:0] w_remain;
  logic [LVL_W-1:0] w_level_n;
  entry_t           w_head_n;

  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop      = r_valid && rx_ready;
  // A pop frees the slot the push lands in, so push-while-full is accepted then
  assign w_push_ok  = w_push && (!w_full || w_pop);
  assign w_rd_ptr_n = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
  assign w_remain   = r_level - LVL_W'(w_pop);
  assign w_level_n  = w_remain + LVL_W'(w_push_ok);

  // Next head: the incoming entry if nothing older remains, else the array slot
  always_comb begin
    w_head_n = '0;
    if (w_level_n != '0) begin
      if (w_remain == '0) w_head_n = w_new;
      else                w_head_n = r_mem[w_rd_ptr_n];
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_new;
  end

  // Pointers, level, head and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_valid   <= 1'b0;
      r_head    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_ptr_n;
      r_level  <= w_level_n;
      r_valid  <= (w_level_n != '0);
      r_head   <= w_head_n;
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
      else if (overrun_clr)           r_overrun <= 1'b0;
    end
  end

  assign rx_data       = r_head.data;
  assign rx_parity_err = r_head.perr;
  assign rx_frame_err  = r_head.ferr;
  assign rx_valid      = r_valid;
  assign rx_level      = r_level;
  assign rx_overrun    = r_overrun;

endmodule
